// File: rtl/datatypes_globals_pkg.sv
// rtl/datatypes_globals_pkg.sv - shared payload/source types and arbiter helpers
package datatypes_globals_pkg;

    typedef logic [31:0] rtl_data_t;

    // Widest source index the arbiter supports (NUM_REQ up to 16)
    localparam int ARB_SRC_W = 4;
    typedef logic [ARB_SRC_W-1:0] arb_src_t;

    // Occupancy of the two-entry output stage
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

    // Wrap an index that is at most 2*n-1 back into 0..n-1
    function automatic int rr_wrap(input int idx, input int n);
        return (idx >= n) ? idx - n : idx;
    endfunction

endpackage

// File: rtl/valid_ready_rr_arbiter_if.sv
// rtl/valid_ready_rr_arbiter_if.sv - requester and downstream handshake bundle
interface valid_ready_rr_arbiter_if
    import datatypes_globals_pkg::*;
#(
    parameter type DATA_T  = rtl_data_t,
    parameter int  NUM_REQ = 4,
    parameter int  SRC_W   = $clog2(NUM_REQ)
) ();

    logic [NUM_REQ-1:0] in_valid;
    logic [NUM_REQ-1:0] in_ready;
    DATA_T              in_data [NUM_REQ];
    logic               out_valid;
    logic               out_ready;
    DATA_T              out_data;
    logic [SRC_W-1:0]   out_src;

    // Requesters and downstream sink
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_src
    );

    // Arbiter side
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_src
    );

endinterface

// File: rtl/valid_ready_skid_buffer.sv
// rtl/valid_ready_skid_buffer.sv - two-entry (main + skid) valid/ready output stage
module valid_ready_skid_buffer
    import datatypes_globals_pkg::*;
#(
    parameter type DATA_T = rtl_data_t
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  s_valid,
    output logic  s_ready,
    input  DATA_T s_data,
    output logic  m_valid,
    input  logic  m_ready,
    output DATA_T m_data
);

    occ_e  occ;
    occ_e  occ_nxt;
    DATA_T main_q;
    DATA_T skid_q;
    logic  push;
    logic  pop;
    logic  load_main;
    logic  main_from_skid;
    logic  load_skid;

    // Readiness depends only on registered occupancy, never on m_ready
    assign s_ready = (occ != OCC_FULL);
    assign m_valid = (occ != OCC_EMPTY);
    assign m_data  = main_q;
    assign push    = s_valid & s_ready;
    assign pop     = m_valid & m_ready;

    // Occupancy next-state and entry load selection
    always_comb begin
        occ_nxt        = occ;
        load_main      = 1'b0;
        main_from_skid = 1'b0;
        load_skid      = 1'b0;
        case (occ)
            OCC_EMPTY: begin
                if (push) begin
                    load_main = 1'b1;
                    occ_nxt   = OCC_ONE;
                end
            end
            OCC_ONE: begin
                if (push && pop) begin
                    load_main = 1'b1;
                end else if (push) begin
                    load_skid = 1'b1;
                    occ_nxt   = OCC_FULL;
                end else if (pop) begin
                    occ_nxt = OCC_EMPTY;
                end
            end
            OCC_FULL: begin
                if (pop) begin
                    main_from_skid = 1'b1;
                    load_skid      = push;
                    occ_nxt        = push ? OCC_FULL : OCC_ONE;
                end
            end
            default: occ_nxt = OCC_EMPTY;
        endcase
    end

    // Occupancy and entry registers; reset discards any buffered beats
    always_ff @(posedge clk) begin
        if (reset) begin
            occ    <= OCC_EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else begin
            occ <= occ_nxt;
            if (load_main) begin
                main_q <= s_data;
            end else if (main_from_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= s_data;
            end
        end
    end

endmodule

// File: rtl/valid_ready_rr_arbiter.sv
// rtl/valid_ready_rr_arbiter.sv - round-robin N:1 valid/ready arbiter with skid output stage
module valid_ready_rr_arbiter
    import datatypes_globals_pkg::*;
#(
    parameter type DATA_T  = rtl_data_t,
    parameter int  NUM_REQ = 4,
    parameter int  SRC_W   = $clog2(NUM_REQ)
) (
    input logic                     clk,
    input logic                     reset,
    valid_ready_rr_arbiter_if.slave bus
);

    typedef struct packed {
        DATA_T            data;
        logic [SRC_W-1:0] src;
    } beat_t;

    logic [SRC_W-1:0] rr_ptr;
    logic [SRC_W-1:0] gnt_idx;
    logic             gnt_found;
    logic             can_accept;
    logic             push;
    beat_t            push_beat;
    beat_t            head_beat;

    // First valid requester at or above rr_ptr, wrapping modulo NUM_REQ
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!gnt_found && bus.in_valid[rr_wrap(int'(rr_ptr) + k, NUM_REQ)]) begin
                gnt_found = 1'b1;
                gnt_idx   = SRC_W'(rr_wrap(int'(rr_ptr) + k, NUM_REQ));
            end
        end
    end

    assign push = gnt_found & can_accept & ~reset;

    // One-hot ready toward the winning requester only
    always_comb begin
        bus.in_ready = '0;
        if (push) begin
            bus.in_ready[gnt_idx] = 1'b1;
        end
    end

    assign push_beat.data = bus.in_data[gnt_idx];
    assign push_beat.src  = gnt_idx;

    // Pointer moves past the winner only when a beat is actually taken
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (push) begin
            rr_ptr <= SRC_W'(rr_wrap(int'(gnt_idx) + 1, NUM_REQ));
        end
    end

    valid_ready_skid_buffer #(
        .DATA_T (beat_t)
    ) u_skid (
        .clk     (clk),
        .reset   (reset),
        .s_valid (push),
        .s_ready (can_accept),
        .s_data  (push_beat),
        .m_valid (bus.out_valid),
        .m_ready (bus.out_ready),
        .m_data  (head_beat)
    );

    assign bus.out_data = head_beat.data;
    assign bus.out_src  = head_beat.src;

endmodule

// File: tb/tb_valid_ready_rr_arbiter.sv
// tb/tb_valid_ready_rr_arbiter.sv - directed self-checking bench for valid_ready_rr_arbiter
module tb_valid_ready_rr_arbiter;
    import datatypes_globals_pkg::*;

    localparam int NUM_REQ = 4;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    valid_ready_rr_arbiter_if #(.DATA_T(rtl_data_t), .NUM_REQ(NUM_REQ)) bus ();

    valid_ready_rr_arbiter #(
        .DATA_T  (rtl_data_t),
        .NUM_REQ (NUM_REQ)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] data_of(input int i);
        return 32'hC0DE_0000 | 32'(i);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset         = 1'b1;
        bus.in_valid  = 4'b1111;
        bus.out_ready = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) bus.in_data[i] = data_of(i);

        // Reset held 3 cycles with all requesters valid
        for (int c = 0; c < 3; c++) begin
            step();
            check("rst_in_ready", 32'(bus.in_ready), 32'h0);
            check("rst_out_valid", 32'(bus.out_valid), 32'h0);
        end
        check("rst_out_data", bus.out_data, 32'h0);
        check("rst_out_src", 32'(bus.out_src), 32'h0);
        reset = 1'b0;
        #1;
        check("first_grant", 32'(bus.in_ready), 32'h1);

        // All valid, sink ready: 0,1,2,3,0,1,2,3 one per cycle
        for (int k = 0; k < 8; k++) begin
            step();
            check("rr_out_valid", 32'(bus.out_valid), 32'h1);
            check("rr_out_src", 32'(bus.out_src), 32'(k % 4));
            check("rr_out_data", bus.out_data, data_of(k % 4));
            check("rr_in_ready", 32'(bus.in_ready), 32'(1 << ((k + 1) % 4)));
        end
        bus.in_valid = 4'b0000;
        step();
        check("drain_out_valid", 32'(bus.out_valid), 32'h0);

        // Backpressure with requesters 0 and 2
        bus.out_ready = 1'b0;
        bus.in_valid  = 4'b0101;
        #1;
        check("bp_grant0", 32'(bus.in_ready), 32'h1);
        step();
        check("bp_head0", 32'(bus.out_src), 32'h0);
        check("bp_grant2", 32'(bus.in_ready), 32'h4);
        step();
        check("bp_full_ready", 32'(bus.in_ready), 32'h0);
        for (int c = 0; c < 3; c++) begin
            step();
            check("bp_hold_valid", 32'(bus.out_valid), 32'h1);
            check("bp_hold_src", 32'(bus.out_src), 32'h0);
            check("bp_hold_data", bus.out_data, data_of(0));
            check("bp_hold_ready", 32'(bus.in_ready), 32'h0);
        end
        bus.out_ready = 1'b1;
        step();
        check("rel_src2", 32'(bus.out_src), 32'h2);
        check("rel_data2", bus.out_data, data_of(2));
        check("rel_grant0", 32'(bus.in_ready), 32'h1);
        step();
        check("rel_src0", 32'(bus.out_src), 32'h0);
        check("rel_valid0", 32'(bus.out_valid), 32'h1);
        bus.in_valid = 4'b0000;
        step();
        check("rel_empty", 32'(bus.out_valid), 32'h0);

        // Pointer at 1 with requesters 0 and 3 valid: 3 wins, pointer wraps to 0
        bus.in_valid = 4'b1001;
        #1;
        check("skip_grant3", 32'(bus.in_ready), 32'h8);
        step();
        check("skip_src3", 32'(bus.out_src), 32'h3);
        check("skip_next0", 32'(bus.in_ready), 32'h1);
        bus.in_valid = 4'b0000;
        step();
        check("skip_empty", 32'(bus.out_valid), 32'h0);

        // Reset while two beats are buffered
        bus.out_ready = 1'b0;
        bus.in_valid  = 4'b1111;
        step();
        step();
        check("mid_full_ready", 32'(bus.in_ready), 32'h0);
        check("mid_full_src", 32'(bus.out_src), 32'h0);
        reset         = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        check("mid_rst_ready", 32'(bus.in_ready), 32'h0);
        step();
        check("mid_rst_valid", 32'(bus.out_valid), 32'h0);
        check("mid_rst_data", bus.out_data, 32'h0);
        reset        = 1'b0;
        bus.in_valid = 4'b0000;
        for (int c = 0; c < 3; c++) begin
            step();
            check("mid_no_ghost", 32'(bus.out_valid), 32'h0);
        end

        // Pointer back at 0 after reset: requester 2 alone wins
        bus.in_valid = 4'b0100;
        #1;
        check("post_rst_grant", 32'(bus.in_ready), 32'h4);
        step();
        check("post_rst_src", 32'(bus.out_src), 32'h2);
        check("post_rst_data", bus.out_data, data_of(2));
        bus.in_valid = 4'b0000;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
